chip_bus_ctrl: RTL
==================

Name: chip_bus_ctrl

Overview:
- Downstream consumer of the Agnus bus-arbitration outputs (dbr, dbwe, chip address). Once per 7 MHz bus slot it performs exactly one chip-RAM access: a DMA access if Agnus owns the slot, otherwise a pending CPU access if the CPU holds the custom bus.
- Drives a request/acknowledge chip-RAM port and returns read data to both the custom data bus and the CPU side.

Parameters:
- TIMEOUT, 3, number of clk cycles after ram_req to wait for ram_ack before the access is aborted (range 1..7).
- IDLE_DATA, 16'hFFFF, value placed on DMA or CPU read data when an access times out.

Ports:
- clk  in  1  system clock
- _reset  in  1  asynchronous active-low reset
- clk7_en  in  1  slot strobe; each high cycle is a slot start
- dbr  in  1  Agnus owns the current slot
- dbwe  in  1  Agnus slot is a write (disk/blitter)
- dma_addr  in  20 [20:1]  Agnus chip address for the slot
- dma_wdata  in  16  custom-bus write data for DMA writes
- dma_rdata  out  16  DMA read data to the custom bus, held until the next slot start
- cpu_custom  in  1  CPU is routed to the custom bus this slot
- cpu_req  in  1  CPU chip-RAM request, level-held until cpu_ack
- cpu_we  in  1  CPU write
- cpu_bs  in  2  CPU byte strobes {upper, lower}
- cpu_addr  in  20 [20:1]  CPU chip address
- cpu_wdata  in  16  CPU write data
- cpu_rdata  out  16  CPU read data, valid while cpu_ack is high
- cpu_ack  out  1  one-cycle completion pulse
- ram_req  out  1  RAM request, single-cycle pulse
- ram_we  out  1  RAM write qualifier
- ram_bs  out  2  RAM byte strobes
- ram_addr  out  20 [20:1]  RAM address
- ram_wdata  out  16  RAM write data
- ram_rdata  in  16  RAM read data, valid while ram_ack is high
- ram_ack  in  1  RAM completion
- bus_err  out  1  one-cycle pulse on timeout or slot overrun

Behaviour:
- Reset: all outputs 0 except dma_rdata = IDLE_DATA. The state machine goes to IDLE and any in-flight access is dropped; ram_req is deasserted immediately and asynchronously.
- States:
  - IDLE: waits for a slot start.
  - REQ: ram_req = 1 for exactly one cycle.
  - WAIT: counts cycles until ram_ack.
  - DONE: one cycle, then returns to IDLE.
- Slot start (clk7_en = 1 while in IDLE):
  - If dbr = 1: DMA access. Latch dma_addr and dbwe; ram_bs = 2'b11; ram_wdata = dma_wdata.
  - Else if cpu_custom and cpu_req and no cpu_ack is being issued this cycle: CPU access. Latch cpu_addr, cpu_we, cpu_bs, cpu_wdata.
  - Else: stay in IDLE; no RAM activity.
  - DMA always wins; the CPU request stays pending across slots.
- Address, we, bs and wdata presented to the RAM are registered at slot start and held stable through DONE.
- WAIT, ram_ack = 1:
  - DMA read: dma_rdata <= ram_rdata.
  - CPU read: cpu_rdata <= ram_rdata.
  - Any CPU access: cpu_ack pulses in the following cycle (DONE).
  - Minimum latency from slot start to cpu_ack is 3 clk cycles.
- ram_ack in the same cycle as ram_req is ignored; the counter starts at REQ + 1.
- Timeout: TIMEOUT cycles in WAIT without ram_ack:
  - bus_err pulses and the state goes to IDLE.
  - DMA read: dma_rdata = IDLE_DATA.
  - CPU: no cpu_ack; the request is retried in the next eligible slot.
- Overrun: clk7_en = 1 while not in IDLE. The slot is skipped (no new access), bus_err pulses, and the current access continues. Any later ram_ack arriving while in IDLE is ignored.
- cpu_req dropped before grant: no access is made. Dropping it mid-access does not abort the access; cpu_ack still pulses.
- dma_rdata is reloaded only by a completed DMA read; it keeps its value otherwise.

Optional Feature:
- Macro CHIP_BUS_STATS_EN.
- When defined, adds three outputs, each a 16-bit saturating counter (holds at 16'hFFFF) cleared by _reset:
  - stat_dma_slots: slots used by DMA.
  - stat_cpu_slots: slots used by the CPU.
  - stat_cpu_blocked: slots where cpu_req = 1 and cpu_custom = 1 but dbr = 1.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- DMA read: dbr = 1, dma_addr = 20'h01234, ram_ack at REQ + 1 with ram_rdata = 16'hBEEF -> ram_addr = 20'h01234, ram_we = 0, ram_bs = 2'b11, dma_rdata = 16'hBEEF held until the next slot start.
- CPU write: dbr = 0, cpu_custom = 1, cpu_req = 1, cpu_we = 1, cpu_bs = 2'b01, cpu_wdata = 16'h00A5 -> ram_we = 1, ram_bs = 2'b01, ram_wdata = 16'h00A5; cpu_ack pulses exactly once, 3 cycles after slot start.
- Contention: cpu_req held, dbr = 1 for 4 slots then 0 -> 4 DMA accesses with no cpu_ack, CPU served in slot 5; stat_cpu_blocked = 4 with CHIP_BUS_STATS_EN.
- Timeout: DMA read, ram_ack never asserted, TIMEOUT = 3 -> bus_err pulses 3 cycles after ram_req, dma_rdata = 16'hFFFF; a CPU read in the same situation is retried in the next slot with no cpu_ack.
- Overrun: ram_ack delayed past the next clk7_en -> that slot is skipped, bus_err pulses, the original access completes normally.
- Reset mid-WAIT: _reset low asynchronously -> ram_req = 0, cpu_ack = 0 and dma_rdata = 16'hFFFF at once; the first slot after release behaves normally.

Source files
------------

// File: rtl/chip_bus_ctrl.sv
// chip_bus_ctrl: chip-RAM slot controller downstream of the Agnus arbiter.
// Each 7 MHz slot start (clk7_en while idle) launches at most one RAM access:
// DMA when Agnus owns the slot, otherwise a pending CPU access on the custom bus.
// Access sequence: IDLE -> REQ (one-cycle ram_req) -> WAIT (ack or timeout) -> DONE.
// Optional macro CHIP_BUS_STATS_EN adds saturating slot-usage counters.
module chip_bus_ctrl #(
    parameter int unsigned TIMEOUT   = 3,
    parameter logic [15:0] IDLE_DATA = 16'hFFFF
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        clk7_en,
    input  logic        dbr,
    input  logic        dbwe,
    input  logic [20:1] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic [15:0] dma_rdata,
    input  logic        cpu_custom,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_bs,
    input  logic [20:1] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        ram_req,
    output logic        ram_we,
    output logic [1:0]  ram_bs,
    output logic [20:1] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic        ram_ack,
    output logic        bus_err
`ifdef CHIP_BUS_STATS_EN
    ,
    output logic [15:0] stat_dma_slots,
    output logic [15:0] stat_cpu_slots,
    output logic [15:0] stat_cpu_blocked
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Last WAIT count value before the access is abandoned.
    localparam logic [2:0] CNT_LAST = 3'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        is_dma_q, is_dma_d;
    logic        we_q, we_d;
    logic [1:0]  bs_q, bs_d;
    logic [20:1] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] dma_rdata_q, dma_rdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;

    logic slot_start;
    logic grant_dma;
    logic grant_cpu;
    logic overrun;
    logic timeout;

    // Slot decode: DMA has absolute priority; CPU only when routed to the custom bus.
    always_comb begin
        slot_start = clk7_en && (state_q == ST_IDLE);
        grant_dma  = slot_start && dbr;
        grant_cpu  = slot_start && !dbr && cpu_custom && cpu_req && !cpu_ack;
        overrun    = clk7_en && (state_q != ST_IDLE);
        timeout    = (state_q == ST_WAIT) && !ram_ack && (cnt_q == CNT_LAST);
    end

    // Next-state and datapath-load logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_dma_d    = is_dma_q;
        we_d        = we_q;
        bs_d        = bs_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_rdata_d = cpu_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_dma) begin
                    state_d  = ST_REQ;
                    is_dma_d = 1'b1;
                    we_d     = dbwe;
                    bs_d     = 2'b11;
                    addr_d   = dma_addr;
                    wdata_d  = dma_wdata;
                end else if (grant_cpu) begin
                    state_d  = ST_REQ;
                    is_dma_d = 1'b0;
                    we_d     = cpu_we;
                    bs_d     = cpu_bs;
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                end
            end
            ST_REQ: begin
                // An ack coinciding with the request is not accepted.
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (ram_ack) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        if (is_dma_q) begin
                            dma_rdata_d = ram_rdata;
                        end else begin
                            cpu_rdata_d = ram_rdata;
                        end
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    if (is_dma_q && !we_q) begin
                        dma_rdata_d = IDLE_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and access registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_dma_q    <= 1'b0;
            we_q        <= 1'b0;
            bs_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dma_rdata_q <= IDLE_DATA;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_dma_q    <= is_dma_d;
            we_q        <= we_d;
            bs_q        <= bs_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    // Strobes decode straight from the state register so reset clears them at once.
    always_comb begin
        ram_req   = (state_q == ST_REQ);
        cpu_ack   = (state_q == ST_DONE) && !is_dma_q;
        bus_err   = timeout || overrun;
        ram_we    = we_q;
        ram_bs    = bs_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        dma_rdata = dma_rdata_q;
        cpu_rdata = cpu_rdata_q;
    end

`ifdef CHIP_BUS_STATS_EN
    logic [15:0] stat_dma_q, stat_cpu_q, stat_blk_q;
    logic        blocked;

    assign blocked = slot_start && dbr && cpu_custom && cpu_req;

    // Saturating counters of slot usage and CPU requests lost to DMA.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            stat_dma_q <= '0;
            stat_cpu_q <= '0;
            stat_blk_q <= '0;
        end else begin
            if (grant_dma && (stat_dma_q != '1)) begin
                stat_dma_q <= stat_dma_q + 16'd1;
            end
            if (grant_cpu && (stat_cpu_q != '1)) begin
                stat_cpu_q <= stat_cpu_q + 16'd1;
            end
            if (blocked && (stat_blk_q != '1)) begin
                stat_blk_q <= stat_blk_q + 16'd1;
            end
        end
    end

    assign stat_dma_slots   = stat_dma_q;
    assign stat_cpu_slots   = stat_cpu_q;
    assign stat_cpu_blocked = stat_blk_q;
`endif

endmodule
